msrv32_ifetch_resp: RTL
=======================

# msrv32_ifetch_resp

Instruction-fetch responder for the msrv32 core. It is the memory-side counterpart of the PC mux. It accepts the 32-bit fetch address the PC stage produces, runs one transaction on the instruction-memory bus, tolerates any number of wait states, and returns the fetched word to decode with a valid/stall handshake. It also handles pipeline flushes, misaligned fetch addresses and an optional bus-timeout fault.

## Interface
- `TIMEOUT_CYCLES`, default 255: wait-state limit before a fetch fault (used only with the timeout macro).
- `NOP_INSTR`, default 32'h0000_0013: word driven on `instr_out` when no valid fetch data is present.

Ports:
- `clk_in` in 1: single clock; all state updates on the rising edge.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `req_valid_in` in 1: PC stage presents a fetch address.
- `i_addr_in` in 32: fetch address.
- `req_ready_out` out 1: request accepted this cycle when `req_valid_in && req_ready_out`.
- `flush_in` in 1: branch/trap redirect; discard any in-flight or held fetch.
- `imem_req_out` out 1: bus request, held as a level until ack.
- `imem_addr_out` out 32: latched fetch address.
- `imem_ack_in` in 1: memory data valid, 1-cycle pulse.
- `imem_rdata_in` in 32: instruction word.
- `instr_valid_out` out 1: `instr_out` is valid for decode.
- `instr_out` out 32: fetched instruction.
- `pc_out` out 32: address of `instr_out`.
- `stall_in` in 1: decode cannot take `instr_out`; hold it.
- `instr_misaligned_out` out 1: delivered entry is a misaligned-fetch exception.
- `fetch_fault_out` out 1: delivered entry is a bus timeout (0 when the macro is absent).

## Operation
- FSM states: IDLE, WAIT, OUT. Reset enters IDLE.
- Reset values of all outputs:
  - `req_ready_out`=1.
  - `imem_req_out`=0, `imem_addr_out`=0.
  - `instr_valid_out`=0, `instr_out`=`NOP_INSTR`, `pc_out`=0.
  - `instr_misaligned_out`=0, `fetch_fault_out`=0.
- `req_ready_out` = (state==IDLE) && !`flush_in`.
- IDLE, accept with `i_addr_in[1:0]`!=0:
  - No bus request is issued.
  - Next state OUT with `instr_out`=`NOP_INSTR`, `pc_out`=addr, `instr_misaligned_out`=1.
- IDLE, accept with an aligned address:
  - Latch addr into `imem_addr_out` and `pc_out`.
  - Next state WAIT.
- WAIT:
  - `imem_req_out`=1 and `imem_addr_out` stays stable until `imem_ack_in`.
  - On ack with no pending drop: capture `imem_rdata_in` into `instr_out`, then go to OUT.
- Flush in WAIT:
  - `flush_in` sets a drop flag; the bus transaction is not aborted.
  - On ack with the drop flag set: discard the data, clear the flag, go to IDLE, and `instr_valid_out` stays 0.
- OUT:
  - `instr_valid_out`=1; `instr_out`, `pc_out` and the flags are held stable.
  - At the edge with `stall_in`=0 or `flush_in`=1, go to IDLE, deassert valid and clear the flags.
  - `instr_out` returns to `NOP_INSTR` on leaving OUT.
- Priority: `flush_in` beats `stall_in`.
- `imem_ack_in` in IDLE or OUT is ignored. This covers a stale ack after reset or after a drop.
- Reset asserted mid-WAIT: go to IDLE immediately, drop `imem_req_out`, and ignore the late ack.

## Timing
- Request accepted at edge N → `imem_req_out`=1 during cycle N+1.
- Ack sampled at edge M → `instr_valid_out`=1 from M, i.e. one cycle after the ack cycle.
- Minimum aligned fetch: accept at edge N, ack during N+1, valid from edge N+2.
  - Throughput is one instruction per 3 cycles without stall.
- Misaligned fetch: valid from edge N+1; throughput is one per 2 cycles.
- The ack is registered, so there is no combinational path from `imem_rdata_in` to `instr_out`.
- All outputs are registered except `req_ready_out`, which depends combinationally on `flush_in`.

## Configuration
- Macro `MSRV32_IFETCH_TIMEOUT_EN`.
- Defined:
  - An 8+-bit wait counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - On reaching `TIMEOUT_CYCLES` without ack: drop `imem_req_out` and go to OUT with `instr_out`=`NOP_INSTR` and `fetch_fault_out`=1.
  - If the drop flag is set at timeout, go to IDLE with no valid.
  - An ack in the same cycle as the timeout takes priority: the data is delivered and there is no fault.
- Undefined: no counter; WAIT waits for ack indefinitely; `fetch_fault_out` is tied to 0.

## Test plan
- Zero-wait fetch:
  - Stimulus: addr 32'h0000_0100 accepted at edge 0; ack with rdata 32'h0050_0093 during cycle 1.
  - Required: `instr_valid_out`=1 from edge 2 with `instr_out`=32'h0050_0093 and `pc_out`=32'h100.
- Wait states plus stall:
  - Stimulus: ack 5 cycles after request; `stall_in`=1 for 3 cycles.
  - Required: `imem_addr_out` stable throughout WAIT; `instr_out` held for 3 cycles; valid drops the cycle after `stall_in`=0.
- Flush during WAIT:
  - Stimulus: `flush_in` pulse 2 cycles into WAIT, ack arrives later.
  - Required: no `instr_valid_out`; state returns to IDLE; the next request at 32'h200 returns its own data.
- Misaligned fetch:
  - Stimulus: addr 32'h0000_0102.
  - Required: `imem_req_out` never asserts; valid=1 with `instr_misaligned_out`=1, `instr_out`=32'h0000_0013, `pc_out`=32'h102.
- Reset mid-WAIT:
  - Stimulus: `rst_n_in` low for 1 cycle, then a stray ack.
  - Required: all outputs return to reset values; the stray ack produces no valid.
- Timeout (macro defined, `TIMEOUT_CYCLES`=4):
  - Stimulus: no ack.
  - Required: `fetch_fault_out`=1 and valid after 4 WAIT cycles; `imem_req_out`=0.

Source files
------------

// File: rtl/msrv32_ifetch_resp_if.sv
// Fetch-path bundle: PC-stage request, instruction-memory bus and decode-side result/stall.
// slave = the fetch responder, master = the surrounding pipeline and memory.
interface msrv32_ifetch_resp_if;
  logic        req_valid_in;
  logic [31:0] i_addr_in;
  logic        req_ready_out;
  logic        flush_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_rdata_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        stall_in;
  logic        instr_misaligned_out;
  logic        fetch_fault_out;

  modport slave (
    input  req_valid_in, i_addr_in, flush_in, imem_ack_in, imem_rdata_in, stall_in,
    output req_ready_out, imem_req_out, imem_addr_out, instr_valid_out, instr_out,
           pc_out, instr_misaligned_out, fetch_fault_out
  );

  modport master (
    output req_valid_in, i_addr_in, flush_in, imem_ack_in, imem_rdata_in, stall_in,
    input  req_ready_out, imem_req_out, imem_addr_out, instr_valid_out, instr_out,
           pc_out, instr_misaligned_out, fetch_fault_out
  );
endinterface

// File: rtl/msrv32_ifetch_resp.sv
// Fetch responder: one imem transaction per accepted PC, valid one cycle after ack, held while decode stalls.
// Accepts only in IDLE; optional bus-timeout fault via MSRV32_IFETCH_TIMEOUT_EN.
module msrv32_ifetch_resp #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input logic                 clk_in,
  input logic                 rst_n_in,
  msrv32_ifetch_resp_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]  state;
  logic        drop;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        misaligned;
  logic        fault;

  logic accept;
  logic drop_now;
  logic timeout;

  assign bus.req_ready_out        = (state == ST_IDLE) && !bus.flush_in;
  assign accept                   = bus.req_valid_in && bus.req_ready_out;
  // A flush in the same cycle as the ack or timeout still kills the fetch.
  assign drop_now                 = drop || bus.flush_in;

  assign bus.imem_req_out         = imem_req;
  assign bus.imem_addr_out        = imem_addr;
  assign bus.instr_valid_out      = instr_valid;
  assign bus.instr_out            = instr;
  assign bus.pc_out               = pc;
  assign bus.instr_misaligned_out = misaligned;
  assign bus.fetch_fault_out      = fault;

`ifdef MSRV32_IFETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;

  assign timeout = (state == ST_WAIT) && !bus.imem_ack_in &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if ((state == ST_WAIT) && !bus.imem_ack_in) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= ST_IDLE;
      drop        <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      pc          <= '0;
      misaligned  <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pc <= bus.i_addr_in;
            if (bus.i_addr_in[1:0] != 2'b00) begin
              state       <= ST_OUT;
              instr_valid <= 1'b1;
              misaligned  <= 1'b1;
              instr       <= NOP_INSTR;
            end else begin
              state     <= ST_WAIT;
              imem_req  <= 1'b1;
              imem_addr <= bus.i_addr_in;
            end
          end
        end
        ST_WAIT: begin
          if (bus.imem_ack_in) begin
            imem_req <= 1'b0;
            drop     <= 1'b0;
            if (drop_now) begin
              state <= ST_IDLE;
            end else begin
              state       <= ST_OUT;
              instr_valid <= 1'b1;
              instr       <= bus.imem_rdata_in;
            end
          end else if (timeout) begin
            imem_req <= 1'b0;
            drop     <= 1'b0;
            if (drop_now) begin
              state <= ST_IDLE;
            end else begin
              state       <= ST_OUT;
              instr_valid <= 1'b1;
              instr       <= NOP_INSTR;
              fault       <= 1'b1;
            end
          end else if (bus.flush_in) begin
            // The bus transaction cannot be aborted; remember to discard its data.
            drop <= 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.flush_in || !bus.stall_in) begin
            state       <= ST_IDLE;
            instr_valid <= 1'b0;
            misaligned  <= 1'b0;
            fault       <= 1'b0;
            instr       <= NOP_INSTR;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
